// File: rtl/accum_job_sched.sv
// accum_job_sched: round-robin two-requester scheduler driving the dual a/b step accumulator.
// Optional ACCUM_CHECK_EN adds the sticky err flag and the running-sum assertion.
module accum_job_sched #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] req_n0,
    input  logic [W-1:0] req_n1,
    input  logic         sel,
    input  logic         abort,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] i,
    output logic [W-1:0] n,
    output logic         done,
    output logic         done_id,
    output logic         done_ok,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic last_win, aborted, win, ok;
    logic [W+1:0] sum_ab, tri_n;
    assign win = (&req) ? ~last_win : req[1];
    assign sum_ab = {2'b0, a} + {2'b0, b};
    assign tri_n = {2'b0, n} + {1'b0, n, 1'b0};
    assign ok = sum_ab == tri_n;
    // last_win doubles as the index of the job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            a        <= '0;
            b        <= '0;
            i        <= '0;
            n        <= '0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            done_ok  <= 1'b0;
            last_win <= 1'b1;
            aborted  <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    gnt      <= win ? 2'b10 : 2'b01;
                    n        <= win ? req_n1 : req_n0;
                    a        <= '0;
                    b        <= '0;
                    i        <= '0;
                    last_win <= win;
                    aborted  <= 1'b0;
                    busy     <= 1'b1;
                    state    <= RUN;
                end
                RUN: if (abort) begin
                    aborted <= 1'b1;
                    state   <= DONE;
                end else if (i == n) begin
                    state <= DONE;
                end else begin
                    i <= i + W'(1);
                    a <= a + (sel ? W'(1) : W'(2));
                    b <= b + (sel ? W'(2) : W'(1));
                end
                DONE: begin
                    done    <= 1'b1;
                    done_id <= last_win;
                    done_ok <= ok && !aborted;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ACCUM_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (state == DONE && !ok && !aborted) err <= 1'b1;
    end
    logic [W+1:0] tri_i;
    assign tri_i = {2'b0, i} + {1'b0, i, 1'b0};
    assert property (@(posedge clk) disable iff (!rst) (state != RUN) || (i > n) || (sum_ab == tri_i));
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_accum_job_sched.sv
// tb_accum_job_sched: directed self-checking bench for accum_job_sched.
module tb_accum_job_sched;
    localparam int W = 11;
    logic         clk = 1'b0, rst = 1'b0, sel = 1'b1, abort = 1'b0;
    logic [1:0]   req = '0, gnt;
    logic [W-1:0] req_n0 = '0, req_n1 = '0, a, b, i, n;
    logic         busy, done, done_id, done_ok, err;
    int passed = 0, total = 0, c = 0, seen = 0;

    accum_job_sched #(.W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_n0(req_n0), .req_n1(req_n1),
        .sel(sel), .abort(abort), .gnt(gnt), .busy(busy), .a(a), .b(b), .i(i),
        .n(n), .done(done), .done_id(done_id), .done_ok(done_ok), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0/1: constant sel, mode 2: sel alternates starting with 0
    task automatic wait_done(input int lim, input int mode, output int cyc);
        cyc = lim + 1;
        for (int k = 1; k <= lim; k++) begin
            sel = (mode == 2) ? ((k % 2) == 0) : mode[0];
            step();
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ab", {a, b}, 0);
        chk("rst_in", {i, n}, 0);
        chk("rst_done", {done, done_id, done_ok, err}, 0);
        step();
        rst = 1'b1;

        req = 2'b01; req_n0 = 200; sel = 1'b1;
        step();
        req = 2'b00;
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_busy", busy, 1);
        wait_done(300, 1, c);
        chk("t1_lat", c, 202);
        chk("t1_a", a, 200);
        chk("t1_b", b, 400);
        chk("t1_i", i, 200);
        chk("t1_ok_id", {done_ok, done_id}, 2'b10);
        chk("t1_busy_off", busy, 0);

        req = 2'b10; req_n1 = 7;
        step();
        req = 2'b00;
        chk("t2_gnt", gnt, 2'b10);
        wait_done(50, 2, c);
        chk("t2_lat", c, 9);
        chk("t2_a", a, 11);
        chk("t2_b", b, 10);
        chk("t2_ok_id", {done_ok, done_id}, 2'b11);

        req = 2'b11; req_n0 = 3; req_n1 = 5;
        step();
        chk("t3_gnt0", gnt, 2'b01);
        chk("t3_n0", n, 3);
        req = 2'b10;
        step();
        chk("t3_gnt_pulse", gnt, 2'b00);
        wait_done(50, 1, c);
        chk("t3_lat0", c, 4);
        chk("t3_id0", done_id, 0);
        step();
        req = 2'b00;
        chk("t3_gnt1", gnt, 2'b10);
        chk("t3_n1", n, 5);
        wait_done(50, 1, c);
        chk("t3_lat1", c, 7);
        chk("t3_id1", {done_ok, done_id}, 2'b11);
        chk("t3_ab1", {a, b}, {11'd5, 11'd10});

        req = 2'b01; req_n0 = 0;
        step();
        req = 2'b00;
        chk("t4_gnt", gnt, 2'b01);
        wait_done(20, 1, c);
        chk("t4_lat", c, 2);
        chk("t4_abi", {a, b, i}, 0);
        chk("t4_ok", done_ok, 1);

        req = 2'b01; req_n0 = 100; sel = 1'b1;
        step();
        req = 2'b00;
        for (int k = 0; k < 60 && i != 40; k++) step();
        chk("t5_i40", i, 40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        seen = 0;
        for (int k = 0; k < 3 && !seen; k++) begin
            step();
            seen = done;
        end
        chk("t5_done", seen, 1);
        chk("t5_abi", {a, b, i}, {11'd40, 11'd80, 11'd40});
        chk("t5_ok", done_ok, 0);
        chk("t5_err", err, 0);

        req = 2'b01; req_n0 = 100;
        step();
        req = 2'b00;
        for (int k = 0; k < 80 && i != 50; k++) step();
        chk("t6_i50", i, 50);
        #3 rst = 1'b0;
        #1;
        chk("t6_async_abin", {a, b, i, n}, 0);
        chk("t6_async_ctl", {gnt, busy, done, done_id, done_ok, err}, 0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | done;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | done;
        end
        chk("t6_no_done", seen, 0);
        req = 2'b01; req_n0 = 2;
        step();
        req = 2'b00;
        chk("t6_gnt", gnt, 2'b01);
        wait_done(20, 1, c);
        chk("t6_lat", c, 4);
        chk("t6_ab", {a, b}, {11'd2, 11'd4});
        chk("t6_ok", {done_ok, done_id}, 2'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
